// File: rtl/key_load_ctrl_if.sv
// Handshake and result bus between the key store / core side and key_load_ctrl.
// The controller uses the slave modport; the key-store side uses master.
interface key_load_ctrl_if #(
    parameter int KEY_W = 8
);
    logic             start;
    logic             kbit_valid;
    logic             kbit_data;
    logic             kbit_ready;
    logic             retry_req;
    logic [KEY_W-1:0] key;
    logic             key_valid;
    logic             busy;
    logic             err;
    logic             lockout;

    modport master (
        output start, kbit_valid, kbit_data,
        input  kbit_ready, retry_req, key, key_valid, busy, err, lockout
    );

    modport slave (
        input  start, kbit_valid, kbit_data,
        output kbit_ready, retry_req, key, key_valid, busy, err, lockout
    );
endinterface

// File: rtl/key_load_ctrl.sv
// Loads a serial, even-parity-protected unlock key with retry on error/timeout
// and a sticky lockout after MAX_RETRY+1 failed attempts.
module key_load_ctrl #(
    parameter int KEY_W     = 8,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic            clk,
    input  logic            rst,
    key_load_ctrl_if.slave  bus
);
    localparam int BW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_PARITY, S_RETRY, S_DONE, S_LOCK
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [KEY_W-1:0] r_shift;
    logic [BW-1:0]    r_bitcnt;
    logic [IW-1:0]    r_idlecnt;
    logic [RW-1:0]    r_retrycnt;
    logic [KEY_W-1:0] r_key;
    logic             r_key_valid;
    logic             r_kbit_ready;
    logic             r_retry_req;
    logic             r_busy;
    logic             r_err;
    logic             r_lockout;

    logic w_active;
    logic w_hs;
    logic w_timeout;
    logic w_pass;
    logic w_fail;

    always_comb begin
        w_next    = r_state;
        w_pass    = 1'b0;
        w_fail    = 1'b0;
        w_active  = (r_state == S_SHIFT) || (r_state == S_PARITY);
        w_hs      = w_active && r_kbit_ready && bus.kbit_valid;
        // A handshake on the expiry cycle wins over the timeout.
        w_timeout = w_active && !w_hs && (r_idlecnt == IW'(TIMEOUT - 1));

        case (r_state)
            S_IDLE:   if (bus.start) w_next = S_SHIFT;
            S_SHIFT: begin
                if (w_hs && (r_bitcnt == BW'(KEY_W - 1))) w_next = S_PARITY;
                else if (w_timeout)                      w_fail = 1'b1;
            end
            S_PARITY: begin
                if (w_hs) begin
                    if (bus.kbit_data == ^r_shift) begin
                        w_pass = 1'b1;
                        w_next = S_DONE;
                    end else begin
                        w_fail = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_fail = 1'b1;
                end
            end
            S_RETRY:  w_next = S_SHIFT;
            S_DONE:   w_next = S_DONE;
            S_LOCK:   w_next = S_LOCK;
            default:  w_next = S_IDLE;
        endcase

        if (w_fail) w_next = (r_retrycnt == RW'(MAX_RETRY)) ? S_LOCK : S_RETRY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_idlecnt    <= '0;
            r_retrycnt   <= '0;
            r_key        <= '0;
            r_key_valid  <= 1'b0;
            r_kbit_ready <= 1'b0;
            r_retry_req  <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_lockout    <= 1'b0;
        end else begin
            r_state      <= w_next;
            // Status outputs are registered decodes of the upcoming state.
            r_kbit_ready <= (w_next == S_SHIFT) || (w_next == S_PARITY);
            r_busy       <= (w_next == S_SHIFT) || (w_next == S_PARITY) || (w_next == S_RETRY);
            r_retry_req  <= (w_next == S_RETRY);
            r_lockout    <= (w_next == S_LOCK);
            r_err        <= w_fail;

            if (w_fail) r_retrycnt <= r_retrycnt + 1'b1;

            if (w_pass) begin
                r_key       <= r_shift;
                r_key_valid <= 1'b1;
            end

            if ((r_state == S_IDLE && bus.start) || r_state == S_RETRY) begin
                r_shift   <= '0;
                r_bitcnt  <= '0;
                r_idlecnt <= '0;
            end else if (w_active) begin
                if (w_hs) begin
                    r_idlecnt <= '0;
                    if (r_state == S_SHIFT) begin
                        r_shift[r_bitcnt] <= bus.kbit_data;
                        r_bitcnt          <= r_bitcnt + 1'b1;
                    end
                end else begin
                    r_idlecnt <= r_idlecnt + 1'b1;
                end
            end
        end
    end

    assign bus.kbit_ready = r_kbit_ready;
    assign bus.retry_req  = r_retry_req;
    assign bus.key        = r_key;
    assign bus.key_valid  = r_key_valid;
    assign bus.busy       = r_busy;
    assign bus.err        = r_err;
    assign bus.lockout    = r_lockout;
endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed bench for key_load_ctrl: table of single-attempt loads plus
// hand-written retry, lockout, timeout, reset and ignored-start sequences.
module tb_key_load_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    key_load_ctrl_if #(.KEY_W(8)) bus ();

    key_load_ctrl #(.KEY_W(8), .MAX_RETRY(3), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_err_seen = 0;
    int n_rr_seen  = 0;

    always @(negedge clk) begin
        if (bus.err)       n_err_seen <= n_err_seen + 1;
        if (bus.retry_req) n_rr_seen  <= n_rr_seen + 1;
    end

    typedef struct {
        logic [7:0] k;
        logic       p;
        logic       ok;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic b);
        bus.kbit_valid = 1'b1;
        bus.kbit_data  = b;
        tick();
        bus.kbit_valid = 1'b0;
    endtask

    task automatic stream(input logic [7:0] k, input logic p);
        for (int i = 0; i < 8; i++) put(k[i]);
        put(p);
    endtask

    task automatic begin_load();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.kbit_valid = 1'b0;
        bus.kbit_data = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // {kbit_ready, retry_req, key_valid, busy, err, lockout, key}
    function automatic logic [31:0] outs();
        return {18'd0, bus.kbit_ready, bus.retry_req, bus.key_valid, bus.busy,
                bus.err, bus.lockout, bus.key};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, r0;
        vecs[0] = '{8'hA5, 1'b0, 1'b1};
        vecs[1] = '{8'h3C, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1'b1};
        vecs[4] = '{8'h01, 1'b1, 1'b1};
        vecs[5] = '{8'h7F, 1'b1, 1'b1};
        vecs[6] = '{8'h80, 1'b0, 1'b0};
        vecs[7] = '{8'h3C, 1'b1, 1'b0};
        vecs[8] = '{8'hFE, 1'b0, 1'b0};
        vecs[9] = '{8'h00, 1'b1, 1'b0};

        bus.start = 1'b0;
        bus.kbit_valid = 1'b0;
        bus.kbit_data = 1'b0;
        do_reset();
        chk("reset_outputs", outs(), 32'd0);

        // Single-attempt table: result visible at cycle 10 after start.
        for (int v = 0; v < 10; v++) begin
            do_reset();
            e0 = n_err_seen;
            r0 = n_rr_seen;
            begin_load();
            for (int i = 0; i < 8; i++) put(vecs[v].k[i]);
            chk("c9_busy_ready", {bus.busy, bus.kbit_ready, bus.key_valid}, 3'b110);
            chk("c9_no_pulse", n_err_seen - e0 + n_rr_seen - r0, 0);
            put(vecs[v].p);
            chk("c10_key", bus.key, vecs[v].ok ? vecs[v].k : 8'h00);
            chk("c10_key_valid", bus.key_valid, vecs[v].ok);
            chk("c10_err", bus.err, !vecs[v].ok);
            chk("c10_retry_req", bus.retry_req, !vecs[v].ok);
            chk("c10_busy_ready", {bus.busy, bus.kbit_ready}, vecs[v].ok ? 2'b00 : 2'b10);
        end

        // One retry: bad 0x3C then good 0x3C.
        do_reset();
        e0 = n_err_seen;
        r0 = n_rr_seen;
        begin_load();
        stream(8'h3C, 1'b1);
        tick();
        chk("retry_shift_ready", {bus.kbit_ready, bus.retry_req, bus.err}, 3'b100);
        stream(8'h3C, 1'b0);
        chk("retry_key", bus.key, 8'h3C);
        chk("retry_key_valid", bus.key_valid, 1'b1);
        chk("retry_err_count", n_err_seen - e0, 1);
        chk("retry_rr_count", n_rr_seen - r0, 1);

        // Lockout after four bad streams.
        do_reset();
        e0 = n_err_seen;
        r0 = n_rr_seen;
        begin_load();
        stream(8'hA5, 1'b1);
        for (int a = 0; a < 3; a++) begin
            tick();
            stream(8'hA5, 1'b1);
        end
        chk("lock_first_cycle", {bus.lockout, bus.err, bus.busy, bus.kbit_ready, bus.retry_req}, 5'b11000);
        tick();
        chk("lock_err_count", n_err_seen - e0, 4);
        chk("lock_rr_count", n_rr_seen - r0, 3);
        begin_load();
        tick();
        tick();
        chk("lock_after_start", outs(), {18'd0, 6'b000001, 8'h00});

        // Timeout after 3 bits, then restart from bit 0.
        do_reset();
        e0 = n_err_seen;
        begin_load();
        put(1'b1); put(1'b1); put(1'b1);
        bus.kbit_data = 1'b1;
        for (int c = 0; c < 15; c++) tick();
        chk("to_before_expiry", {bus.err, bus.kbit_ready}, 2'b01);
        tick();
        chk("to_expiry", {bus.err, bus.retry_req, bus.busy, bus.kbit_ready}, 4'b1110);
        tick();
        stream(8'h96, 1'b0);
        chk("to_key", bus.key, 8'h96);
        chk("to_key_valid", bus.key_valid, 1'b1);
        chk("to_err_count", n_err_seen - e0, 1);

        // Handshake on the expiry cycle is not a timeout; idle data is ignored.
        do_reset();
        e0 = n_err_seen;
        begin_load();
        put(1'b0); put(1'b1);
        bus.kbit_data = 1'b1;
        for (int c = 0; c < 15; c++) begin
            bus.kbit_data = ~bus.kbit_data;
            tick();
        end
        put(1'b1); put(1'b0); put(1'b0); put(1'b1); put(1'b1); put(1'b0);
        put(1'b0);
        chk("edge_hs_key", bus.key, 8'h66);
        chk("edge_hs_valid", bus.key_valid, 1'b1);
        chk("edge_hs_no_err", n_err_seen - e0, 0);

        // Reset after 5 bits.
        do_reset();
        begin_load();
        for (int i = 0; i < 5; i++) put(1'b1);
        rst = 1'b1;
        bus.kbit_valid = 1'b1;
        bus.kbit_data = 1'b1;
        tick();
        chk("midrst_outputs", outs(), 32'd0);
        rst = 1'b0;
        bus.kbit_valid = 1'b0;
        tick();
        chk("midrst_idle", outs(), 32'd0);
        begin_load();
        stream(8'hFF, 1'b0);
        chk("midrst_reload_key", {bus.key_valid, bus.key}, {1'b1, 8'hFF});

        // Start pulses during SHIFT and DONE are ignored.
        do_reset();
        begin_load();
        put(1'b1); put(1'b0); put(1'b0);
        bus.start = 1'b1;
        put(1'b1);
        bus.start = 1'b0;
        put(1'b1); put(1'b1); put(1'b0); put(1'b0);
        put(1'b0);
        chk("ign_shift_key", {bus.key_valid, bus.key}, {1'b1, 8'h39});
        begin_load();
        tick();
        tick();
        chk("ign_done_hold", outs(), {18'd0, 6'b001000, 8'h39});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
